// File: rtl/alu_op_sequencer.sv
// Command/response sequencer in front of a latch-style 4-bit ALU: registers operands, waits SETTLE cycles, captures results.
// Optional build macro ALU_CHECK_EN adds a reference model of the ALU and a sticky chk_err mismatch flag.
module alu_op_sequencer #(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [3:0]       alu_res,
    input  logic             alu_car,
    input  logic             alu_of,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_res,
    output logic             rsp_car,
    output logic             rsp_of,
    output logic             rsp_zero,
    output logic [CNT_W-1:0] op_count
`ifdef ALU_CHECK_EN
    ,
    output logic             chk_err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] settle_cnt;
    logic       cmd_fire;
    logic       capture;
    logic       rsp_fire;

    assign cmd_fire = (state == IDLE) && cmd_valid;
    assign capture  = (state == DRIVE) && (settle_cnt == 4'd0);
    assign rsp_fire = (state == RESP) && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = DRIVE;
            DRIVE:   if (settle_cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // cmd_ready is masked by rst so nothing is offered while reset is applied.
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE:    cmd_ready = !rst;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_ctrl   <= 3'b000;
            settle_cnt <= 4'd0;
        end else if (cmd_fire) begin
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            alu_ctrl   <= cmd_op;
            settle_cnt <= SETTLE_LOAD;
        end else if ((state == DRIVE) && (settle_cnt != 4'd0)) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_res  <= 4'd0;
            rsp_car  <= 1'b0;
            rsp_of   <= 1'b0;
            rsp_zero <= 1'b1;
        end else if (capture) begin
            rsp_res  <= alu_res;
            rsp_car  <= alu_car;
            rsp_of   <= alu_of;
            rsp_zero <= (alu_res == 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (rsp_fire) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

`ifdef ALU_CHECK_EN
    logic [3:0] exp_res;
    logic       exp_car;
    logic       exp_of;
    logic [4:0] sum;
    logic [3:0] neg_b;

    // Overflow for sub deliberately uses b, not its negation, to mirror the ALU.
    always_comb begin
        exp_res = 4'd0;
        exp_car = 1'b0;
        exp_of  = 1'b0;
        sum     = 5'd0;
        neg_b   = ~alu_b + 4'd1;
        case (alu_ctrl)
            3'b000: begin
                sum     = {1'b0, alu_a} + {1'b0, alu_b};
                exp_res = sum[3:0];
                exp_car = sum[4];
                exp_of  = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
            end
            3'b001: begin
                sum     = {1'b0, alu_a} + {1'b0, neg_b};
                exp_res = sum[3:0];
                exp_car = sum[4];
                exp_of  = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
            end
            3'b010: exp_res = ~alu_a;
            3'b011: exp_res = alu_a & alu_b;
            3'b100: exp_res = alu_a | alu_b;
            3'b101: exp_res = alu_a ^ alu_b;
            3'b110: begin
                if (!alu_a[3] && alu_b[3]) begin
                    exp_res = 4'd0;
                end else if (alu_a[3] && !alu_b[3]) begin
                    exp_res = 4'd1;
                end else begin
                    exp_res = (alu_a < alu_b) ? 4'd0 : 4'd1;
                end
            end
            default: exp_res = (alu_a == alu_b) ? 4'd0 : 4'd1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err <= 1'b0;
        end else if (capture &&
                     ((exp_res != alu_res) || (exp_car != alu_car) || (exp_of != alu_of))) begin
            chk_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised bench for alu_op_sequencer with a behavioural ALU and transaction-level expectations.
module tb_alu_op_sequencer;

    localparam int SETTLE = 3;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_a;
    logic [3:0]       cmd_b;
    logic [2:0]       cmd_op;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [2:0]       alu_ctrl;
    logic [3:0]       alu_res;
    logic             alu_car;
    logic             alu_of;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [3:0]       rsp_res;
    logic             rsp_car;
    logic             rsp_of;
    logic             rsp_zero;
    logic [CNT_W-1:0] op_count;
`ifdef ALU_CHECK_EN
    logic             chk_err;
`endif

    logic inject_car = 1'b0;
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   exp_count  = 0;
    logic [6:0] got;

    always #5 clk = ~clk;

    alu_op_sequencer #(.SETTLE(SETTLE), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_res(alu_res), .alu_car(alu_car), .alu_of(alu_of),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_car(rsp_car), .rsp_of(rsp_of), .rsp_zero(rsp_zero),
        .op_count(op_count)
`ifdef ALU_CHECK_EN
        , .chk_err(chk_err)
`endif
    );

    // Behavioural ALU, returns {car, of, res}, written with integer arithmetic.
    function automatic logic [5:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] op);
        int ia, ib, s, r;
        logic c, o;
        ia = int'(a);
        ib = int'(b);
        c  = 1'b0;
        o  = 1'b0;
        r  = 0;
        case (op)
            3'd0: begin s = ia + ib; r = s % 16; c = (s > 15); end
            3'd1: begin s = ia + ((16 - ib) % 16); r = s % 16; c = (s > 15); end
            3'd2: r = 15 - ia;
            3'd3: r = int'(a & b);
            3'd4: r = int'(a | b);
            3'd5: r = int'(a ^ b);
            3'd6: begin
                if (ia < 8 && ib >= 8)      r = 0;
                else if (ia >= 8 && ib < 8) r = 1;
                else                        r = (ia < ib) ? 0 : 1;
            end
            default: r = (ia == ib) ? 0 : 1;
        endcase
        if (op == 3'd0 || op == 3'd1)
            o = ((ia >= 8) == (ib >= 8)) && ((r >= 8) != (ia >= 8));
        return {c, o, 4'(r)};
    endfunction

    always_comb begin
        logic [5:0] v;
        v = alu_model(alu_a, alu_b, alu_ctrl);
        alu_res = v[3:0];
        alu_of  = v[4];
        alu_car = v[5] | inject_car;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction; returns {zero, car, of, res} seen on the response channel.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                         input int stall, output logic [6:0] seen);
        logic [5:0] e;
        logic [6:0] hold;
        int guard;
        e = alu_model(a, b, op);
        e[5] = e[5] | inject_car;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            step();
            guard++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_a = a; cmd_b = b; cmd_op = op;
        rsp_ready = (stall == 0);
        step();
        cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom);
        check("accept_ready_low", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < SETTLE; i++) begin
            check("drive_no_valid", 32'(rsp_valid), 32'd0);
            check("drive_alu_hold", 32'({alu_a, alu_b, alu_ctrl}), 32'({a, b, op}));
            cmd_valid = 1'($urandom_range(0, 1));
            step();
        end
        cmd_valid = 1'b0;
        check("rsp_valid_up", 32'(rsp_valid), 32'd1);
        check("rsp_res", 32'(rsp_res), 32'(e[3:0]));
        check("rsp_car", 32'(rsp_car), 32'(e[5]));
        check("rsp_of", 32'(rsp_of), 32'(e[4]));
        check("rsp_zero", 32'(rsp_zero), 32'(e[3:0] == 4'd0));
        hold = {rsp_zero, rsp_car, rsp_of, rsp_res};
        seen = hold;
        for (int s = 0; s < stall; s++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_a = 4'($urandom);
            step();
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_hold", 32'({rsp_zero, rsp_car, rsp_of, rsp_res}), 32'(hold));
            check("stall_ready_low", 32'(cmd_ready), 32'd0);
            check("stall_alu_hold", 32'({alu_a, alu_b, alu_ctrl}), 32'({a, b, op}));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        exp_count = (exp_count + 1) % (1 << CNT_W);
        check("hs_valid_down", 32'(rsp_valid), 32'd0);
        check("hs_op_count", 32'(op_count), 32'(exp_count));
        check("hs_cmd_ready", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        step();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu", 32'({alu_a, alu_b, alu_ctrl}), 32'd0);
        check("rst_rsp", 32'({rsp_zero, rsp_car, rsp_of, rsp_res}), 32'h40);
        check("rst_op_count", 32'(op_count), 32'd0);
        exp_count = 0;
        rst = 1'b0;
        step();
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = 4'd0; cmd_b = 4'd0; cmd_op = 3'd0;
        step();
        do_reset();
        check("idle_zero", 32'(rsp_zero), 32'd1);
        check("idle_ctrl", 32'(alu_ctrl), 32'd0);

        do_op(4'd7, 4'd1, 3'b000, 0, got);
        check("add_const", 32'(got), 32'b0011000);
        do_op(4'd3, 4'd5, 3'b001, 0, got);
        check("sub_const", 32'(got), 32'b0011110);
        do_op(4'd4, 4'd4, 3'b111, 5, got);
        check("eq_const", 32'(got), 32'b1000000);

        // Abort an operation mid-DRIVE.
        cmd_valid = 1'b1; cmd_a = 4'd9; cmd_b = 4'd2; cmd_op = 3'b000;
        step();
        cmd_valid = 1'b0;
        step();
        check("abort_in_drive", 32'(rsp_valid), 32'd0);
        do_reset();
        for (int i = 0; i < SETTLE + 1; i++) begin
            step();
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check("abort_count", 32'(op_count), 32'd0);
        do_op(4'b1010, 4'b0110, 3'b101, 1, got);
        check("xor_const", 32'(got), 32'b0001100);

        for (int n = 0; n < 40; n++)
            do_op(4'($urandom), 4'($urandom), 3'($urandom), $urandom_range(0, 3), got);

`ifdef ALU_CHECK_EN
        check("chk_clean", 32'(chk_err), 32'd0);
        inject_car = 1'b1;
        do_op(4'd5, 4'd3, 3'b011, 0, got);
        inject_car = 1'b0;
        check("chk_set", 32'(chk_err), 32'd1);
        do_op(4'd2, 4'd6, 3'b100, 1, got);
        check("chk_sticky", 32'(chk_err), 32'd1);
        do_reset();
        check("chk_rst", 32'(chk_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
